// File: rtl/way_array.sv
// way_array: one cache set of WAYS ways, each holding WIDTH bits of data with
// valid and dirty bits and an LRU age. A flush FSM walks the ways and offers
// every valid+dirty way on a ready/valid write-back port.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   index           - way addressed by write / inval / touch and the read outputs
//   write, wmask,
//   set_dirty,
//   datain          - byte-masked write; stores set_dirty as the dirty bit
//   inval           - clear valid+dirty of way index (wins over write)
//   touch           - mark way index most recently used
//   dataout,
//   valid_out,
//   dirty_out       - combinational contents of way index
//   victim          - lowest invalid way, else the least recently used way
//   flush_req       - start a flush scan (only accepted when idle)
//   flush_busy      - flush in progress
//   wb_valid, wb_ready,
//   wb_index, wb_data - write-back handshake for dirty ways
//   flush_done      - single-cycle pulse when the scan completes
module way_array #(
    parameter int WIDTH = 128,
    parameter int WAYS  = 4,
    localparam int IW   = $clog2(WAYS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IW-1:0]      index,
    input  logic               write,
    input  logic [WIDTH/8-1:0] wmask,
    input  logic               set_dirty,
    input  logic [WIDTH-1:0]   datain,
    input  logic               inval,
    input  logic               touch,
    output logic [WIDTH-1:0]   dataout,
    output logic               valid_out,
    output logic               dirty_out,
    output logic [IW-1:0]      victim,
    input  logic               flush_req,
    output logic               flush_busy,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [IW-1:0]      wb_index,
    output logic [WIDTH-1:0]   wb_data,
    output logic               flush_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } state_t;

    logic [WIDTH-1:0] data_q  [WAYS];
    logic [WIDTH-1:0] data_d  [WAYS];
    logic [IW-1:0]    age_q   [WAYS];
    logic [IW-1:0]    age_d   [WAYS];
    logic [WAYS-1:0]  valid_q, valid_d;
    logic [WAYS-1:0]  dirty_q, dirty_d;
    state_t           state_q, state_d;
    logic [IW-1:0]    p_q, p_d;

    logic             busy;
    logic             write_ok;
    logic             inval_ok;
    logic             age_upd;
    logic [WAYS-1:0]  younger;   // ways more recent than the one being promoted

    assign busy     = (state_q != ST_IDLE);
    assign inval_ok = inval && !busy;
    // inval takes priority, so a write in the same cycle is not accepted at all
    assign write_ok = write && !inval && !busy;
    assign age_upd  = touch || write_ok;

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_younger
        assign younger[gi] = (age_q[gi] < age_q[index]);
    end

    always_comb begin
        data_d  = data_q;
        age_d   = age_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        state_d = state_q;
        p_d     = p_q;

        if (inval_ok) begin
            valid_d[index] = 1'b0;
            dirty_d[index] = 1'b0;
        end else if (write_ok) begin
            valid_d[index] = 1'b1;
            dirty_d[index] = set_dirty;
            for (int b = 0; b < WIDTH / 8; b++) begin
                if (wmask[b]) begin
                    data_d[index][b*8 +: 8] = datain[b*8 +: 8];
                end
            end
        end

        // Promote the addressed way to age 0 and shift the more recent ones
        // down by one; older ways keep their age, preserving the permutation.
        if (age_upd) begin
            for (int i = 0; i < WAYS; i++) begin
                if (IW'(i) == index) begin
                    age_d[i] = '0;
                end else if (younger[i]) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end

        // Writes are blocked while busy, so the dirty clear below never
        // collides with a write to the same way.
        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d = ST_SCAN;
                    p_d     = '0;
                end
            end
            ST_SCAN: begin
                if (valid_q[p_q] && dirty_q[p_q]) begin
                    state_d = ST_EMIT;
                end else if (p_q == IW'(WAYS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    p_d = p_q + 1'b1;
                end
            end
            ST_EMIT: begin
                if (wb_ready) begin
                    dirty_d[p_q] = 1'b0;
                    if (p_q == IW'(WAYS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SCAN;
                        p_d     = p_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WAYS; i++) begin
                data_q[i] <= '0;
                age_q[i]  <= IW'(i);
            end
            valid_q <= '0;
            dirty_q <= '0;
            state_q <= ST_IDLE;
            p_q     <= '0;
        end else begin
            data_q  <= data_d;
            age_q   <= age_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            state_q <= state_d;
            p_q     <= p_d;
        end
    end

    // Victim: the LRU way is the fallback; the descending scan for invalid
    // ways overrides it so the lowest-index invalid way ends up selected.
    always_comb begin
        victim = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (age_q[i] == IW'(WAYS - 1)) begin
                victim = IW'(i);
            end
        end
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                victim = IW'(i);
            end
        end
    end

    assign dataout    = data_q[index];
    assign valid_out  = valid_q[index];
    assign dirty_out  = dirty_q[index];
    assign flush_busy = busy;
    assign wb_valid   = (state_q == ST_EMIT);
    assign wb_index   = p_q;
    assign wb_data    = data_q[p_q];
    assign flush_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_way_array.sv
// Directed bench for way_array (WIDTH=128, WAYS=4): byte writes, LRU victim
// order, invalidate priority, flush with back-pressure, empty flush timing and
// reset in the middle of a flush.
module tb_way_array;

    localparam int WIDTH = 128;
    localparam int WAYS  = 4;
    localparam int IW    = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [IW-1:0]      index;
    logic               write;
    logic [WIDTH/8-1:0] wmask;
    logic               set_dirty;
    logic [WIDTH-1:0]   datain;
    logic               inval;
    logic               touch;
    logic [WIDTH-1:0]   dataout;
    logic               valid_out;
    logic               dirty_out;
    logic [IW-1:0]      victim;
    logic               flush_req;
    logic               flush_busy;
    logic               wb_valid;
    logic               wb_ready;
    logic [IW-1:0]      wb_index;
    logic [WIDTH-1:0]   wb_data;
    logic               flush_done;

    int n_checks = 0;
    int n_errors = 0;

    way_array #(.WIDTH(WIDTH), .WAYS(WAYS)) dut (
        .clk        (clk),
        .rst        (rst),
        .index      (index),
        .write      (write),
        .wmask      (wmask),
        .set_dirty  (set_dirty),
        .datain     (datain),
        .inval      (inval),
        .touch      (touch),
        .dataout    (dataout),
        .valid_out  (valid_out),
        .dirty_out  (dirty_out),
        .victim     (victim),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_index   (wb_index),
        .wb_data    (wb_data),
        .flush_done (flush_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // one clock edge; inputs change and outputs are sampled 1 ns after it
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [IW-1:0] idx, input logic [7:0] fill,
                      input logic dirty);
        index     = idx;
        write     = 1'b1;
        wmask     = '1;
        datain    = {16{fill}};
        set_dirty = dirty;
        tick();
        write     = 1'b0;
        set_dirty = 1'b0;
    endtask

    task automatic wait_wb(input string tag);
        int n;
        n = 0;
        while (!wb_valid && n < 20) begin
            tick();
            n++;
        end
        check(tag, WIDTH'(wb_valid), WIDTH'(1));
    endtask

    logic [WIDTH-1:0] held;
    int done_cnt;
    int wbv_cnt;

    initial begin
        rst = 1'b0; index = '0; write = 1'b0; wmask = '0; set_dirty = 1'b0;
        datain = '0; inval = 1'b0; touch = 1'b0; flush_req = 1'b0; wb_ready = 1'b0;
        tick();

        // reset state
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        index = 2'd2;
        check("rst_dataout", dataout, '0);
        check("rst_valid", WIDTH'(valid_out), '0);
        check("rst_dirty", WIDTH'(dirty_out), '0);
        check("rst_victim", WIDTH'(victim), '0);
        check("rst_busy", WIDTH'(flush_busy), '0);
        check("rst_wb_valid", WIDTH'(wb_valid), '0);
        check("rst_flush_done", WIDTH'(flush_done), '0);

        // byte-masked write
        index = 2'd2; write = 1'b1; wmask = 16'h0003; datain = {16{8'hAA}};
        set_dirty = 1'b1;
        tick();
        write = 1'b0; set_dirty = 1'b0;
        check("bw_data", dataout, 128'h0000AAAA);
        check("bw_valid", WIDTH'(valid_out), WIDTH'(1));
        check("bw_dirty", WIDTH'(dirty_out), WIDTH'(1));
        check("bw_victim", WIDTH'(victim), WIDTH'(0));

        // LRU: ages after fill are {3,2,1,0}
        do_reset();
        for (int i = 0; i < WAYS; i++) wr(IW'(i), 8'h10 + 8'(i), 1'b0);
        index = 2'd3;
        check("fill_data3", dataout, {16{8'h13}});
        check("fill_dirty3", WIDTH'(dirty_out), '0);
        check("fill_victim", WIDTH'(victim), WIDTH'(0));
        index = 2'd0; touch = 1'b1; tick(); touch = 1'b0;
        check("touch0_victim", WIDTH'(victim), WIDTH'(1));
        index = 2'd1; touch = 1'b1; tick(); touch = 1'b0;
        check("touch1_victim", WIDTH'(victim), WIDTH'(2));

        // invalidate; ages now {1,0,3,2}
        index = 2'd2; inval = 1'b1; tick(); inval = 1'b0;
        check("inval_victim", WIDTH'(victim), WIDTH'(2));
        check("inval_valid", WIDTH'(valid_out), '0);
        check("inval_data", dataout, {16{8'h12}});
        wr(2'd2, 8'h55, 1'b1);  // ages {2,1,0,3}
        check("rewrite_victim", WIDTH'(victim), WIDTH'(3));
        index = 2'd2; write = 1'b1; inval = 1'b1; wmask = '1; datain = '1;
        set_dirty = 1'b1;
        tick();
        write = 1'b0; inval = 1'b0; set_dirty = 1'b0;
        check("wi_valid", WIDTH'(valid_out), '0);
        check("wi_dirty", WIDTH'(dirty_out), '0);
        check("wi_data", dataout, {16{8'h55}});
        check("wi_victim", WIDTH'(victim), WIDTH'(2));

        // flush with ways 1 and 3 dirty and back-pressure on the first offer
        do_reset();
        for (int i = 0; i < WAYS; i++) wr(IW'(i), 8'h20 + 8'(i), (i == 1 || i == 3));
        wb_ready = 1'b0;
        flush_req = 1'b1; tick(); flush_req = 1'b0;
        check("fl_busy", WIDTH'(flush_busy), WIDTH'(1));
        // write while busy must be ignored
        wr(2'd0, 8'hEE, 1'b1);
        wait_wb("fl_wb1_valid");
        check("fl_wb1_index", WIDTH'(wb_index), WIDTH'(1));
        check("fl_wb1_data", wb_data, {16{8'h21}});
        held = wb_data;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("fl_hold_valid", WIDTH'(wb_valid), WIDTH'(1));
            check("fl_hold_index", WIDTH'(wb_index), WIDTH'(1));
            check("fl_hold_data", wb_data, held);
        end
        wb_ready = 1'b1;
        tick();
        wait_wb("fl_wb3_valid");
        check("fl_wb3_index", WIDTH'(wb_index), WIDTH'(3));
        check("fl_wb3_data", wb_data, {16{8'h23}});
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (flush_done) done_cnt++;
        end
        wb_ready = 1'b0;
        check("fl_done_pulses", WIDTH'(done_cnt), WIDTH'(1));
        check("fl_idle", WIDTH'(flush_busy), '0);
        index = 2'd1;
        check("fl_dirty1", WIDTH'(dirty_out), '0);
        check("fl_valid1", WIDTH'(valid_out), WIDTH'(1));
        index = 2'd3;
        check("fl_dirty3", WIDTH'(dirty_out), '0);
        index = 2'd0;
        check("fl_ignored_wr", dataout, {16{8'h20}});

        // flush with nothing dirty: DONE on the 5th sample after flush_req
        flush_req = 1'b1; tick(); flush_req = 1'b0;
        wbv_cnt = 0;
        done_cnt = 0;
        for (int c = 2; c <= 4; c++) begin
            tick();
            if (wb_valid) wbv_cnt++;
            if (flush_done) done_cnt++;
        end
        tick();
        check("ef_done_at5", WIDTH'(flush_done), WIDTH'(1));
        check("ef_early_done", WIDTH'(done_cnt), '0);
        tick();
        check("ef_done_low", WIDTH'(flush_done), '0);
        check("ef_idle", WIDTH'(flush_busy), '0);
        check("ef_no_wb", WIDTH'(wbv_cnt), '0);

        // reset during EMIT
        wr(2'd2, 8'h77, 1'b1);
        flush_req = 1'b1; tick(); flush_req = 1'b0;
        wait_wb("rm_wb_valid");
        rst = 1'b1; tick(); rst = 1'b0;
        check("rm_wb_valid_low", WIDTH'(wb_valid), '0);
        check("rm_busy", WIDTH'(flush_busy), '0);
        check("rm_done", WIDTH'(flush_done), '0);
        for (int i = 0; i < WAYS; i++) begin
            index = IW'(i);
            #1;
            check("rm_invalid", WIDTH'(valid_out), '0);
        end
        done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (flush_done) done_cnt++;
        end
        check("rm_no_pulse", WIDTH'(done_cnt), '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
